// File: rtl/viterbi_pkg.sv
// viterbi_pkg
//   Shared definitions for the Viterbi frame scheduler: default datapath
//   widths, the default decode timeout and the scheduler state encoding.
package viterbi_pkg;

  localparam int DEF_SIZE_DATA_IN  = 16;
  localparam int DEF_SIZE_DATA_OUT = 8;
  localparam int DEF_TIMEOUT_CYC   = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. Picks the first asserted request at
//   or after ptr, wrapping modulo N.
// Ports
//   req  in   N      request vector
//   ptr  in   IDX_W  highest-priority index for this decision
//   gnt  out  N      one-hot grant (all zero when no request)
//   idx  out  IDX_W  index of the granted request
//   any  out  1      at least one request present
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] cand;

  // The request vector is doubled and the lower copy is masked below ptr, so
  // a plain lowest-set-bit scan over 2N bits gives the wrapped round-robin
  // winner; the upper copy supplies the wrap-around candidates.
  always_comb begin
    req_dbl = {req, req};
    mask    = '0;
    for (int i = 0; i < 2*N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    cand = req_dbl & mask;

    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      if (cand[i] && !any) begin
        any          = 1'b1;
        idx          = IDX_W'(i % N);
        gnt[i % N]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/viterbi_frame_scheduler.sv
// viterbi_frame_scheduler
//   Shares one Viterbi decode datapath between NUM_REQ requesters. Grants
//   requesters round-robin, launches the datapath with the captured frame,
//   watches for done with a timeout, and returns the decoded byte tagged
//   with the owning requester ID.
// Ports
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_req           per-requester request, held until granted
//   i_req_data      frame k at [k*SIZE_DATA_IN +: SIZE_DATA_IN]
//   o_grant         one-hot 1-cycle grant pulse (frame captured this cycle)
//   o_dec_start     1-cycle datapath start pulse
//   o_dec_data      captured frame to the datapath
//   i_dec_data      decoded byte from the datapath
//   i_dec_done      datapath done pulse (only honoured while waiting)
//   o_dec_flush     1-cycle datapath reset request on timeout
//   o_resp_valid    response valid, held until i_resp_ready
//   o_resp_id       requester owning the response
//   o_resp_data     decoded byte (0 on timeout)
//   o_resp_err      1 = timed out
//   i_resp_ready    response accept
//   o_busy          scheduler not idle
//
// state     | meaning
// ST_IDLE   | waiting for any request
// ST_GRANT  | arbitrate on current requests, pulse grant, capture frame
// ST_LAUNCH | pulse start to the datapath, clear timeout counter
// ST_WAIT   | waiting for done or timeout
// ST_RESP   | response presented until accepted
module viterbi_frame_scheduler
  import viterbi_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SIZE_DATA_IN  = DEF_SIZE_DATA_IN,
  parameter int SIZE_DATA_OUT = DEF_SIZE_DATA_OUT,
  parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_REQ-1:0]              i_req,
  input  logic [NUM_REQ*SIZE_DATA_IN-1:0] i_req_data,
  output logic [NUM_REQ-1:0]              o_grant,
  output logic                            o_dec_start,
  output logic [SIZE_DATA_IN-1:0]         o_dec_data,
  input  logic [SIZE_DATA_OUT-1:0]        i_dec_data,
  input  logic                            i_dec_done,
  output logic                            o_dec_flush,
  output logic                            o_resp_valid,
  output logic [ID_W-1:0]                 o_resp_id,
  output logic [SIZE_DATA_OUT-1:0]        o_resp_data,
  output logic                            o_resp_err,
  input  logic                            i_resp_ready,
  output logic                            o_busy
);

  // The counter only has to reach TIMEOUT_CYC-1.
  localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  state_t                   state_q, state_d;
  logic [ID_W-1:0]          ptr_q, ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SIZE_DATA_IN-1:0]  dec_data_q, dec_data_d;
  logic [ID_W-1:0]          resp_id_q, resp_id_d;
  logic [SIZE_DATA_OUT-1:0] resp_data_q, resp_data_d;
  logic                     resp_err_q, resp_err_d;

  logic [NUM_REQ-1:0]       arb_gnt;
  logic [ID_W-1:0]          arb_idx;
  logic                     arb_any;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_arbiter (
    .req (i_req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      dec_data_q  <= '0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      dec_data_q  <= dec_data_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    dec_data_d  = dec_data_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    o_grant     = '0;
    o_dec_start = 1'b0;
    o_dec_flush = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|i_req) state_d = ST_GRANT;
      end
      // Arbitration looks at i_req in this cycle, so a request that has
      // dropped since IDLE is simply not a candidate any more.
      ST_GRANT: begin
        if (arb_any) begin
          o_grant    = arb_gnt;
          dec_data_d = i_req_data[arb_idx*SIZE_DATA_IN +: SIZE_DATA_IN];
          resp_id_d  = arb_idx;
          ptr_d      = (arb_idx == LAST_ID) ? '0 : arb_idx + 1'b1;
          state_d    = ST_LAUNCH;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        o_dec_start = 1'b1;
        cnt_d       = '0;
        state_d     = ST_WAIT;
      end
      // Done takes priority over the timeout limit in the same cycle.
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (i_dec_done) begin
          resp_data_d = i_dec_data;
          resp_err_d  = 1'b0;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          o_dec_flush = 1'b1;
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_dec_data   = dec_data_q;
  assign o_resp_valid = (state_q == ST_RESP);
  assign o_resp_id    = resp_id_q;
  assign o_resp_data  = resp_data_q;
  assign o_resp_err   = resp_err_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_viterbi_frame_scheduler.sv
// tb_viterbi_frame_scheduler
//   Transaction-level reference model for the Viterbi frame scheduler:
//   tracks pending requesters, their frames and the round-robin pointer,
//   and predicts grant, launch, flush and response for each frame.
module tb_viterbi_frame_scheduler;

  localparam int N    = 4;
  localparam int DIN  = 16;
  localparam int DOUT = 8;
  localparam int T    = 64;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*DIN-1:0]  req_data;
  logic [N-1:0]      grant;
  logic              dec_start;
  logic [DIN-1:0]    dec_data_o;
  logic [DOUT-1:0]   dec_data_i;
  logic              dec_done;
  logic              dec_flush;
  logic              resp_valid;
  logic [IW-1:0]     resp_id;
  logic [DOUT-1:0]   resp_data;
  logic              resp_err;
  logic              resp_ready;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int             mptr;
  logic [N-1:0]   pend;
  logic [DIN-1:0] fdata [N];

  always #5 clk = ~clk;

  viterbi_frame_scheduler #(
    .NUM_REQ       (N),
    .SIZE_DATA_IN  (DIN),
    .SIZE_DATA_OUT (DOUT),
    .TIMEOUT_CYC   (T)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .i_req_data   (req_data),
    .o_grant      (grant),
    .o_dec_start  (dec_start),
    .o_dec_data   (dec_data_o),
    .i_dec_data   (dec_data_i),
    .i_dec_done   (dec_done),
    .o_dec_flush  (dec_flush),
    .o_resp_valid (resp_valid),
    .o_resp_id    (resp_id),
    .o_resp_data  (resp_data),
    .o_resp_err   (resp_err),
    .i_resp_ready (resp_ready),
    .o_busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic add_req(input int j, input logic [DIN-1:0] d);
    if (!pend[j]) begin
      pend[j]  = 1'b1;
      fdata[j] = d;
    end
  endtask

  task automatic drive_req();
    for (int j = 0; j < N; j++) req_data[j*DIN +: DIN] = fdata[j];
    req = pend;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},  busy, 0);
    check_eq({tag, "_grant"}, grant, 0);
    check_eq({tag, "_start"}, dec_start, 0);
    check_eq({tag, "_flush"}, dec_flush, 0);
    check_eq({tag, "_valid"}, resp_valid, 0);
    check_eq({tag, "_ddata"}, dec_data_o, 0);
    check_eq({tag, "_id"},    resp_id, 0);
    check_eq({tag, "_rdata"}, resp_data, 0);
    check_eq({tag, "_err"},   resp_err, 0);
  endtask

  // Called at the start of a cycle in which the DUT is idle.
  // k: WAIT cycle (counter value) on which done is driven; k >= T means never.
  // stall: cycles of ready low before accept. rst_at: WAIT cycle to reset in (-1 none).
  task automatic run_txn(input int k, input logic [DOUT-1:0] byte_v, input int stall, input int rst_at);
    int w;
    logic             exp_err;
    logic [DOUT-1:0]  exp_data;

    if (pend == '0) add_req($urandom_range(0, N-1), 16'($urandom));
    drive_req();
    w = -1;
    for (int i = 0; i < N; i++) begin
      if (w < 0 && pend[(mptr + i) % N]) w = (mptr + i) % N;
    end
    smp();
    check_eq("idle_busy", busy, 0);
    check_eq("idle_valid", resp_valid, 0);
    check_eq("idle_grant", grant, 0);

    cyc(); smp();
    check_eq("grant", grant, 64'(1) << w);
    check_eq("grant_busy", busy, 1);

    cyc();
    pend[w] = 1'b0;
    drive_req();
    smp();
    check_eq("start", dec_start, 1);
    check_eq("dec_data", dec_data_o, fdata[w]);
    check_eq("launch_grant", grant, 0);
    mptr = (w + 1) % N;

    for (int c = 0; c < T; c++) begin
      cyc();
      if (c == rst_at) begin
        rst = 1'b1;
        dec_done = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        check_all_zero("rst");
        mptr = 0;
        return;
      end
      dec_done   = (c == k);
      dec_data_i = (c == k) ? byte_v : DOUT'($urandom);
      smp();
      check_eq("flush", dec_flush, (c == T-1 && k != c));
      check_eq("wait_start", dec_start, 0);
      if (c == k || c == T-1) break;
    end
    exp_err  = (k > T-1);
    exp_data = exp_err ? '0 : byte_v;

    for (int s = 0; s <= stall; s++) begin
      cyc();
      dec_done   = 1'($urandom_range(0, 1));
      dec_data_i = DOUT'($urandom);
      resp_ready = (s == stall);
      smp();
      check_eq("resp_valid", resp_valid, 1);
      check_eq("resp_id", resp_id, w);
      check_eq("resp_data", resp_data, exp_data);
      check_eq("resp_err", resp_err, exp_err);
      check_eq("resp_grant", grant, 0);
      check_eq("resp_flush", dec_flush, 0);
    end
    cyc();
    dec_done   = 1'b0;
    resp_ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req        = '0;
    req_data   = '0;
    dec_done   = 1'b0;
    dec_data_i = '0;
    resp_ready = 1'b0;
    mptr       = 0;
    pend       = '0;
    for (int j = 0; j < N; j++) fdata[j] = '0;

    repeat (3) cyc();
    smp();
    check_all_zero("reset");
    cyc();
    rst = 1'b0;

    // request withdrawn before arbitration: no grant, back to idle
    req = 4'b0010;
    smp();
    cyc();
    req = '0;
    smp();
    check_eq("drop_grant", grant, 0);
    cyc(); smp();
    check_eq("drop_idle", busy, 0);
    cyc();

    // single request, done after 20 cycles
    add_req(2, 16'hA5C3);
    run_txn(20, 8'h3C, 0, -1);

    // timeout, then done exactly on the limit cycle
    run_txn(1000, 8'h77, 1, -1);
    run_txn(T-1, 8'hE1, 0, -1);

    // backpressure with others pending
    for (int j = 0; j < N; j++) add_req(j, 16'($urandom));
    run_txn(5, 8'h5A, 10, -1);

    // reset during WAIT, then all requesting: rotation restarts at 0
    run_txn(30, 8'h11, 0, 10);
    for (int f = 0; f < 8; f++) begin
      for (int j = 0; j < N; j++) add_req(j, 16'($urandom));
      run_txn($urandom_range(0, 40), 8'($urandom), 0, -1);
    end

    // random traffic
    for (int f = 0; f < 40; f++) begin
      int k;
      for (int j = 0; j < N; j++) if ($urandom_range(0, 2) == 0) add_req(j, 16'($urandom));
      case ($urandom_range(0, 5))
        0:       k = T-1;
        1:       k = T + 10;
        default: k = $urandom_range(0, T-2);
      endcase
      run_txn(k, 8'($urandom), $urandom_range(0, 4),
              ($urandom_range(0, 14) == 0) ? $urandom_range(0, 5) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
